// File: rtl/ir_store_pkg.sv
// Shared constants and FSM encoding for the IR store op-channel scheduler.
package ir_store_pkg;

    localparam int OP_W = 3;
    localparam int ID_W = 3;

    localparam logic [OP_W-1:0] OP_IDLE = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_WAIT_DONE = 2'b01,
        S_WAIT_CLR  = 2'b10,
        S_ACK       = 2'b11
    } sched_state_e;

endpackage

// File: rtl/ir_store_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after ptr_i wins.
module ir_store_rr_arbiter
    import ir_store_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               valid_o
);

    int best_dist_s;
    int dist_s;

    // pick the requester with the smallest rotated distance from ptr_i+1
    always_comb begin
        best_dist_s = NUM_REQ;
        dist_s      = 0;
        idx_o       = '0;
        valid_o     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            dist_s = (k + NUM_REQ - int'(ptr_i) - 1) % NUM_REQ;
            if (req_i[k] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                idx_o       = ID_W'(k);
                valid_o     = 1'b1;
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

    // expand the winning index into a one-hot grant
    always_comb begin
        gnt_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            gnt_o[k] = valid_o && (idx_o == ID_W'(k));
        end
    end

endmodule

// File: rtl/ir_store_op_scheduler.sv
// Issues one op at a time onto the CDC op-code lines and runs the 4-phase
// code/done handshake, with a per-phase timeout that aborts a hung op.
module ir_store_op_scheduler
    import ir_store_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int TIMEOUT_W = 16
) (
    input  logic                    iClk_Global,
    input  logic                    iRst,
    input  logic [NUM_REQ-1:0]      iReq,
    input  logic [3*NUM_REQ-1:0]    iReq_Op,
    output logic [NUM_REQ-1:0]      oAck,
    output logic                    oErr,
    output logic                    oBusy,
    output logic [ID_W-1:0]         oActive_Id,
    output logic [OP_W-1:0]         oOp_Code,
    input  logic                    iOp_Done
);

    localparam logic [TIMEOUT_W-1:0] TIMER_MAX  = '1;
    // a phase may last 2**TIMEOUT_W-1 cycles; the last one is seen with timer at max-1
    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    sched_state_e           state_q, state_d;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic                   err_flag_q, err_flag_d;
    logic [OP_W-1:0]        code_q, code_d;
    logic                   busy_q, busy_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   err_q, err_d;

    logic [NUM_REQ-1:0]     valid_req_s;
    logic [NUM_REQ-1:0]     gnt_s;
    logic [ID_W-1:0]        gnt_idx_s;
    logic                   gnt_valid_s;
    logic [OP_W-1:0]        win_op_s;
    logic                   issue_s;
    logic                   timeout_s;

    // requests carrying the IDLE code are not real ops
    always_comb begin
        valid_req_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            valid_req_s[k] = iReq[k] && (iReq_Op[3*k +: 3] != OP_IDLE);
        end
    end

    ir_store_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (valid_req_s),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt_s),
        .idx_o   (gnt_idx_s),
        .valid_o (gnt_valid_s)
    );

    // mux the winner's op code
    always_comb begin
        win_op_s = OP_IDLE;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_s[k]) begin
                win_op_s = iReq_Op[3*k +: 3];
            end else begin
                win_op_s = win_op_s;
            end
        end
    end

    assign issue_s   = gnt_valid_s && !iOp_Done;
    assign timeout_s = (timer_q == TIMER_LAST);

    // state register
    always_ff @(posedge iClk_Global or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (issue_s) state_d = S_WAIT_DONE;
                else         state_d = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (iOp_Done || timeout_s) state_d = S_WAIT_CLR;
                else                       state_d = S_WAIT_DONE;
            end
            S_WAIT_CLR: begin
                if (!iOp_Done || timeout_s) state_d = S_ACK;
                else                        state_d = S_WAIT_CLR;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // output and datapath next values
    always_comb begin
        code_d     = code_q;
        busy_d     = busy_q;
        ack_d      = '0;
        err_d      = 1'b0;
        id_d       = id_q;
        ptr_d      = ptr_q;
        err_flag_d = err_flag_q;
        case (state_q)
            S_IDLE: begin
                busy_d = issue_s;
                if (issue_s) begin
                    id_d       = gnt_idx_s;
                    ptr_d      = gnt_idx_s;
                    code_d     = win_op_s;
                    err_flag_d = 1'b0;
                end else begin
                    code_d = OP_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (iOp_Done) begin
                    code_d = OP_IDLE;
                end else if (timeout_s) begin
                    code_d     = OP_IDLE;
                    err_flag_d = 1'b1;
                end else begin
                    code_d = code_q;
                end
            end
            S_WAIT_CLR: begin
                if (iOp_Done && timeout_s) begin
                    err_flag_d = 1'b1;
                end else begin
                    err_flag_d = err_flag_q;
                end
            end
            S_ACK: begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    ack_d[k] = (id_q == ID_W'(k));
                end
                err_d      = err_flag_q;
                err_flag_d = 1'b0;
            end
            default: begin
                code_d = OP_IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    // per-phase timer: clears on every state change, saturates otherwise
    always_comb begin
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q == TIMER_MAX) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // datapath and output registers
    always_ff @(posedge iClk_Global or posedge iRst) begin
        if (iRst) begin
            timer_q    <= '0;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            id_q       <= '0;
            err_flag_q <= 1'b0;
            code_q     <= OP_IDLE;
            busy_q     <= 1'b0;
            ack_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            err_flag_q <= err_flag_d;
            code_q     <= code_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign oAck       = ack_q;
    assign oErr       = err_q;
    assign oBusy      = busy_q;
    assign oActive_Id = id_q;
    assign oOp_Code   = code_q;

endmodule

// File: tb/tb_ir_store_op_scheduler.sv
// Scenario bench for ir_store_op_scheduler with a scoreboard of expected ops/acks.
module tb_ir_store_op_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [8:0] req_op;
    logic [2:0] ack;
    logic       err;
    logic       busy;
    logic [2:0] act_id;
    logic [2:0] code;
    logic       done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         id;
        logic [2:0] op;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    exp_t       popped;
    logic [2:0] prev_code = 3'b000;

    ir_store_op_scheduler #(.NUM_REQ(3), .TIMEOUT_W(4)) dut (
        .iClk_Global (clk),
        .iRst        (rst),
        .iReq        (req),
        .iReq_Op     (req_op),
        .oAck        (ack),
        .oErr        (err),
        .oBusy       (busy),
        .oActive_Id  (act_id),
        .oOp_Code    (code),
        .iOp_Done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // monitor: every issued code and every ack is checked against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (code != prev_code && code != 3'b000) begin
                total++;
                if (prev_code !== 3'b000) begin
                    bad++;
                    $display("FAIL op_to_op: code went %b -> %b without IDLE", prev_code, code);
                end
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_issue: code=%b id=%0d with empty scoreboard", code, act_id);
                end else if (code !== sb[0].op || act_id !== 3'(sb[0].id)) begin
                    bad++;
                    $display("FAIL issue: got code=%b id=%0d, want code=%b id=%0d",
                             code, act_id, sb[0].op, sb[0].id);
                end
            end
            if (ack !== 3'b000) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ack: ack=%b err=%b", ack, err);
                end else begin
                    popped = sb.pop_front();
                    if (ack !== (3'b001 << popped.id) || err !== popped.err) begin
                        bad++;
                        $display("FAIL ack: got ack=%b err=%b, want ack=%b err=%b",
                                 ack, err, 3'b001 << popped.id, popped.err);
                    end
                end
            end
        end
        prev_code <= code;
    end

    task automatic wait_code(input logic nonzero, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((code != 3'b000) == nonzero) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ack(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack != 3'b000) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // local-side responder for one op; returns at the negedge where the ack is seen
    task automatic respond(input int delay, output bit ok);
        bit o1, o2, o3;
        wait_code(1'b1, 20, o1);
        repeat (delay) @(negedge clk);
        done = 1'b1;
        wait_code(1'b0, 20, o2);
        done = 1'b0;
        wait_ack(20, o3);
        ok = o1 && o2 && o3;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 3'b000; req_op = 9'd0; done = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (code !== 3'b000 || busy !== 1'b0 || ack !== 3'b000 || err !== 1'b0 || act_id !== 3'd0) begin
            bad++;
            $display("FAIL reset_state: code=%b busy=%b ack=%b err=%b id=%0d, want all 0",
                     code, busy, ack, err, act_id);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || code !== 3'b000) begin
            bad++;
            $display("FAIL reset_release: busy=%b code=%b, want 0/000", busy, code);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        sb.push_back('{0, 3'b001, 1'b0});
        sb.push_back('{1, 3'b010, 1'b0});
        sb.push_back('{2, 3'b011, 1'b0});
        sb.push_back('{0, 3'b001, 1'b0});
        req_op = {3'b011, 3'b010, 3'b001};
        req    = 3'b111;
        for (int i = 0; i < 4; i++) begin
            respond(2, ok);
            if (i == 3) req = 3'b000;
            total++;
            if (ok !== 1'b1) begin
                bad++;
                $display("FAIL rr_handshake: op %0d timed out (ok=%b want 1)", i, ok);
            end
        end
        @(negedge clk);
        req_op = 9'd0;
    endtask

    task automatic test_single();
        sb.push_back('{0, 3'b011, 1'b0});
        req_op = 9'b000_000_011;
        req    = 3'b001;
        @(negedge clk);
        total++;
        if (code !== 3'b011 || busy !== 1'b1 || act_id !== 3'd0) begin
            bad++;
            $display("FAIL t1_issue: code=%b busy=%b id=%0d, want 011/1/0", code, busy, act_id);
        end
        repeat (4) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        total++;
        if (code !== 3'b000 || ack !== 3'b000) begin
            bad++;
            $display("FAIL t1_idle: code=%b ack=%b, want 000/000", code, ack);
        end
        done = 1'b0;
        @(negedge clk);
        total++;
        if (ack !== 3'b000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL t1_ack_early: ack=%b busy=%b, want 000/1", ack, busy);
        end
        @(negedge clk);
        total++;
        if (ack !== 3'b001 || err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL t1_ack: ack=%b err=%b busy=%b, want 001/0/1", ack, err, busy);
        end
        req = 3'b000;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || ack !== 3'b000) begin
            bad++;
            $display("FAIL t1_release: busy=%b ack=%b, want 0/000", busy, ack);
        end
    endtask

    task automatic test_timeout();
        int cnt;
        sb.push_back('{2, 3'b110, 1'b1});
        req_op = 9'b110_000_000;
        req    = 3'b100;
        @(negedge clk);
        total++;
        if (code !== 3'b110) begin
            bad++;
            $display("FAIL t3_issue: code=%b, want 110", code);
        end
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (code != 3'b000) cnt++;
            else break;
        end
        total++;
        if (cnt !== 15) begin
            bad++;
            $display("FAIL t3_code_cycles: code held %0d cycles, want 15", cnt);
        end
        @(negedge clk);
        total++;
        if (ack !== 3'b000) begin
            bad++;
            $display("FAIL t3_ack_early: ack=%b, want 000", ack);
        end
        @(negedge clk);
        total++;
        if (ack !== 3'b100 || err !== 1'b1) begin
            bad++;
            $display("FAIL t3_ack: ack=%b err=%b, want 100/1", ack, err);
        end
        req = 3'b000; req_op = 9'd0;
        @(negedge clk);
        total++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL t3_err_pulse: err=%b busy=%b, want 0/0", err, busy);
        end
    endtask

    task automatic test_stale_done();
        bit stuck, ok;
        done = 1'b1;
        sb.push_back('{1, 3'b010, 1'b0});
        req_op = 9'b000_010_000;
        req    = 3'b010;
        stuck  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (code !== 3'b000 || busy !== 1'b0) stuck = 1'b1;
        end
        total++;
        if (stuck !== 1'b0) begin
            bad++;
            $display("FAIL t4_blocked: issued while done stale (flag=%b, want 0)", stuck);
        end
        done = 1'b0;
        @(negedge clk);
        total++;
        if (code !== 3'b010 || act_id !== 3'd1) begin
            bad++;
            $display("FAIL t4_issue: code=%b id=%0d, want 010/1", code, act_id);
        end
        respond(1, ok);
        req = 3'b000; req_op = 9'd0;
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL t4_handshake: ok=%b, want 1", ok);
        end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        sb.push_back('{0, 3'b001, 1'b0});
        req_op = 9'b000_000_001;
        req    = 3'b001;
        @(negedge clk);
        total++;
        if (code !== 3'b001) begin
            bad++;
            $display("FAIL t5_issue: code=%b, want 001", code);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (code !== 3'b000 || busy !== 1'b0 || ack !== 3'b000) begin
            bad++;
            $display("FAIL t5_reset: code=%b busy=%b ack=%b, want 000/0/000", code, busy, ack);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{0, 3'b001, 1'b0});
        @(negedge clk);
        total++;
        if (code !== 3'b001 || busy !== 1'b1 || act_id !== 3'd0) begin
            bad++;
            $display("FAIL t5_reserve: code=%b busy=%b id=%0d, want 001/1/0", code, busy, act_id);
        end
        respond(1, ok);
        req = 3'b000; req_op = 9'd0;
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL t5_handshake: ok=%b, want 1", ok);
        end
    endtask

    task automatic test_invalid_op();
        bit ok, stuck;
        sb.push_back('{2, 3'b101, 1'b0});
        req_op = {3'b101, 3'b000, 3'b000};
        req    = 3'b110;
        respond(1, ok);
        req = 3'b010;
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL t6_handshake: ok=%b, want 1", ok);
        end
        stuck = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (code !== 3'b000 || (busy !== 1'b0 && ack === 3'b000)) stuck = 1'b1;
        end
        total++;
        if (stuck !== 1'b0) begin
            bad++;
            $display("FAIL t6_idle_op_ignored: activity flag=%b, want 0", stuck);
        end
        req = 3'b000; req_op = 9'd0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_stale_done();
        test_reset_mid_op();
        test_invalid_op();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
